// File: rtl/tc_mul_pipe.sv
// tc_mul_pipe: pipelined, back-pressurable fixed-point multiplier.
// The exact product, optional rounding, arithmetic right shift and saturation
// are all computed combinationally from the operands. The result then enters a
// NUM_STAGE-deep register chain. Every stage advances on one global enable, so
// the result is bit-identical for any NUM_STAGE and only latency changes.
module tc_mul_pipe #(
    parameter int A_WIDTH    = 13,
    parameter int B_WIDTH    = 17,
    parameter int A_SIGNED   = 0,
    parameter int B_SIGNED   = 1,
    parameter int DOUT_WIDTH = 30,
    parameter int SHIFT      = 0,
    parameter int ROUND      = 0,
    parameter int NUM_STAGE  = 1
) (
    input  logic                         ap_clk,
    input  logic                         ap_rst_n,
    input  logic                         din_valid,
    output logic                         din_ready,
    input  logic [A_WIDTH-1:0]           din0,
    input  logic [B_WIDTH-1:0]           din1,
    output logic                         dout_valid,
    input  logic                         dout_ready,
    output logic signed [DOUT_WIDTH-1:0] dout,
    output logic                         ovf
);

    // The product is one bit wider than the operand sum, so mixed
    // signed/unsigned products fit exactly. One more bit lets the rounding
    // add proceed without overflow.
    localparam int PW = A_WIDTH + B_WIDTH + 1;
    localparam int SW = PW + 1;

    logic signed [PW-1:0]         w_a_ext;
    logic signed [PW-1:0]         w_b_ext;
    logic signed [PW-1:0]         w_prod;
    logic signed [SW-1:0]         w_prod_x;
    logic signed [SW-1:0]         w_rnd;
    logic signed [SW-1:0]         w_sum;
    logic signed [SW-1:0]         w_scaled;
    logic signed [DOUT_WIDTH-1:0] w_dout;
    logic                         w_ovf;
    logic                         w_ce;

    logic [NUM_STAGE-1:0]                 r_vld_pipe;
    logic [NUM_STAGE-1:0][DOUT_WIDTH-1:0] r_dout_pipe;
    logic [NUM_STAGE-1:0]                 r_ovf_pipe;

    // Extend each operand to the full product width according to its signedness.
    if (A_SIGNED != 0) begin : g_a_sx
        assign w_a_ext = PW'($signed(din0));
    end else begin : g_a_zx
        assign w_a_ext = $signed(PW'(din0));
    end

    if (B_SIGNED != 0) begin : g_b_sx
        assign w_b_ext = PW'($signed(din1));
    end else begin : g_b_zx
        assign w_b_ext = $signed(PW'(din1));
    end

    assign w_prod   = w_a_ext * w_b_ext;
    assign w_prod_x = SW'(w_prod);

    // Round half up: add half an output LSB before the shift discards it.
    if (ROUND != 0 && SHIFT > 0) begin : g_rnd
        assign w_rnd = SW'(1) << (SHIFT - 1);
    end else begin : g_trunc
        assign w_rnd = '0;
    end

    assign w_sum    = w_prod_x + w_rnd;
    assign w_scaled = w_sum >>> SHIFT;

    if (DOUT_WIDTH >= SW) begin : g_wide
        // The output can hold every scaled value, so saturation never occurs.
        assign w_dout = DOUT_WIDTH'(w_scaled);
        assign w_ovf  = 1'b0;
    end else begin : g_sat
        // The value is in range when every bit from the output sign bit upward
        // matches the sign.
        logic [SW-DOUT_WIDTH:0] w_hi;
        assign w_hi = w_scaled[SW-1:DOUT_WIDTH-1];

        // Clamp to the violated bound and flag the overflow.
        always_comb begin
            w_ovf  = 1'b0;
            w_dout = w_scaled[DOUT_WIDTH-1:0];
            if (!((&w_hi) || !(|w_hi))) begin
                w_ovf  = 1'b1;
                w_dout = w_scaled[SW-1] ? {1'b1, {(DOUT_WIDTH-1){1'b0}}}
                                        : {1'b0, {(DOUT_WIDTH-1){1'b1}}};
            end
        end
    end

    // The whole chain moves when the output slot is empty or is being drained.
    // Bubbles are held in place, which keeps the stall logic to a single gate.
    assign w_ce      = !r_vld_pipe[NUM_STAGE-1] || dout_ready;
    assign din_ready = w_ce;

    // Pipeline register chain: stage 0 captures the new result, and later stages shift.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_vld_pipe  <= '0;
            r_dout_pipe <= '0;
            r_ovf_pipe  <= '0;
        end else if (w_ce) begin
            r_vld_pipe[0]  <= din_valid;
            r_dout_pipe[0] <= w_dout;
            r_ovf_pipe[0]  <= w_ovf;
            for (int s = 1; s < NUM_STAGE; s++) begin
                r_vld_pipe[s]  <= r_vld_pipe[s-1];
                r_dout_pipe[s] <= r_dout_pipe[s-1];
                r_ovf_pipe[s]  <= r_ovf_pipe[s-1];
            end
        end
    end

    assign dout_valid = r_vld_pipe[NUM_STAGE-1];
    assign dout       = r_dout_pipe[NUM_STAGE-1];
    assign ovf        = r_ovf_pipe[NUM_STAGE-1];

endmodule
